phase_modulator: RTL

//  Transmit-side counterpart of the CORDIC direction receiver. Accepts one direction bit per handshake
//  and moves a 16-bit phase accumulator +/-PHASE_STEP per output sample, SPS samples per bit
//  (PHASE_STEP*SPS = 90 deg default, MSK-style). Each sample phase is turned into a 4-bit signed I/Q pair
//  by an iterative rotation-mode CORDIC. The I/Q stream feeds the DAC path / loopback into the receiver.

---
 rtl/phase_modulator.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/phase_modulator.sv
// Phase-continuous MSK-style I/Q source: one direction bit -> SPS CORDIC samples (MOD_DIFF_ENC_EN: differential bit encoding).
// Latency: ITER+2 cycles from accept to first o_enable_out strobe, then one sample every ITER+2 cycles.
// Backpressure: o_ready only while waiting for a bit; i_enable_in while busy is dropped; output cannot stall.
module phase_modulator #(
    parameter int SPS        = 4,
    parameter int PHASE_STEP = 4096,
    parameter int ITER       = 8,
    parameter int W          = 12,
    parameter int AMP_INIT   = 1088
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_enable_in,
    input  logic              i_dir,
    output logic              o_ready,
    output logic              o_enable_out,
    output logic signed [3:0] o_I,
    output logic signed [3:0] o_Q
);

    localparam int CW = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [CW-1:0]        LAST_SAMPLE = CW'(SPS - 1);
    localparam logic [3:0]           LAST_ITER   = 4'(ITER - 1);
    localparam logic [15:0]          STEP        = 16'(PHASE_STEP);
    localparam logic signed [W-1:0]  AMP         = W'(AMP_INIT);
    localparam logic signed [W:0]    HALF        = (W+1)'(1 << (W - 5));
    localparam logic signed [W:0]    QMAX        = (W+1)'(7);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ENABLE_IN,
        LOAD,
        ITERATE,
        OUTPUT
    } state_t;

    state_t                state, state_nxt;
    logic [15:0]           phase;
    logic                  dir_q;
    logic                  eff_dir;
    logic [CW-1:0]         sample_cnt;
    logic [3:0]            iter_cnt;
    logic signed [W-1:0]   x, y;
    logic signed [16:0]    z;
    logic signed [W-1:0]   x_sh, y_sh, x_nxt, y_nxt;
    logic signed [16:0]    z_nxt;
    logic                  rot_ccw;

    function automatic logic signed [16:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 17'sd8192;
            4'd1:    atan_lut = 17'sd4836;
            4'd2:    atan_lut = 17'sd2555;
            4'd3:    atan_lut = 17'sd1297;
            4'd4:    atan_lut = 17'sd651;
            4'd5:    atan_lut = 17'sd326;
            4'd6:    atan_lut = 17'sd163;
            4'd7:    atan_lut = 17'sd81;
            4'd8:    atan_lut = 17'sd41;
            4'd9:    atan_lut = 17'sd20;
            4'd10:   atan_lut = 17'sd10;
            4'd11:   atan_lut = 17'sd5;
            default: atan_lut = 17'sd0;
        endcase
    endfunction

    // Round half up to 4 bits, then clamp symmetrically so -8 is never emitted.
    function automatic logic signed [3:0] quant(input logic signed [W-1:0] v);
        logic signed [W:0] t;
        t = ($signed({v[W-1], v}) + HALF) >>> (W - 4);
        if (t > QMAX)
            quant = 4'sd7;
        else if (t < -QMAX)
            quant = -4'sd7;
        else
            quant = t[3:0];
    endfunction

    function automatic logic [15:0] step_phase(input logic [15:0] p, input logic d);
        step_phase = d ? (p + STEP) : (p - STEP);
    endfunction

`ifdef MOD_DIFF_ENC_EN
    logic prev_dir;

    assign eff_dir = i_dir ^ prev_dir;

    always_ff @(posedge clock) begin
        if (!reset)
            prev_dir <= 1'b0;
        else if (state == WAIT_ENABLE_IN && i_enable_in)
            prev_dir <= eff_dir;
    end
`else
    assign eff_dir = i_dir;
`endif

    assign rot_ccw = ~z[16];
    assign x_sh    = x >>> iter_cnt;
    assign y_sh    = y >>> iter_cnt;
    assign x_nxt   = rot_ccw ? (x - y_sh) : (x + y_sh);
    assign y_nxt   = rot_ccw ? (y + x_sh) : (y - x_sh);
    assign z_nxt   = rot_ccw ? (z - atan_lut(iter_cnt)) : (z + atan_lut(iter_cnt));

    always_ff @(posedge clock) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        o_ready      = 1'b0;
        o_enable_out = 1'b0;
        case (state)
            IDLE:           state_nxt = WAIT_ENABLE_IN;
            WAIT_ENABLE_IN: begin
                o_ready = 1'b1;
                if (i_enable_in)
                    state_nxt = LOAD;
            end
            LOAD:           state_nxt = ITERATE;
            ITERATE: begin
                if (iter_cnt == LAST_ITER)
                    state_nxt = OUTPUT;
            end
            OUTPUT: begin
                o_enable_out = 1'b1;
                state_nxt    = (sample_cnt == LAST_SAMPLE) ? WAIT_ENABLE_IN : LOAD;
            end
            default:        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            phase      <= 16'd0;
            dir_q      <= 1'b0;
            sample_cnt <= '0;
            iter_cnt   <= 4'd0;
            x          <= '0;
            y          <= '0;
            z          <= '0;
            o_I        <= 4'sd0;
            o_Q        <= 4'sd0;
        end else begin
            case (state)
                WAIT_ENABLE_IN: begin
                    if (i_enable_in) begin
                        dir_q      <= eff_dir;
                        sample_cnt <= '0;
                        phase      <= step_phase(phase, eff_dir);
                    end
                end
                LOAD: begin
                    // Quadrant pre-rotation keeps the residual angle in [0, 90) deg.
                    case (phase[15:14])
                        2'd0: begin x <= AMP;  y <= '0;   end
                        2'd1: begin x <= '0;   y <= AMP;  end
                        2'd2: begin x <= -AMP; y <= '0;   end
                        default: begin x <= '0; y <= -AMP; end
                    endcase
                    z        <= {3'b000, phase[13:0]};
                    iter_cnt <= 4'd0;
                end
                ITERATE: begin
                    x        <= x_nxt;
                    y        <= y_nxt;
                    z        <= z_nxt;
                    iter_cnt <= iter_cnt + 4'd1;
                    if (iter_cnt == LAST_ITER) begin
                        o_I <= quant(x_nxt);
                        o_Q <= quant(y_nxt);
                    end
                end
                OUTPUT: begin
                    if (sample_cnt != LAST_SAMPLE) begin
                        sample_cnt <= sample_cnt + 1'b1;
                        phase      <= step_phase(phase, dir_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
